// File: rtl/inst_fetch_queue_if.sv
// Fetch front-end bundle: redirect input, icache CPU-side port and decode-side FIFO head.
// master = fetch queue side, slave = icache/decode/redirect environment side.
interface inst_fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_cache;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_adel;
    logic        fetch_ready;

    modport master (
        input  redirect, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, fetch_ready,
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata, inst_cache,
               fetch_valid, fetch_pc, fetch_inst, fetch_adel
    );

    modport slave (
        output redirect, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, fetch_ready,
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata, inst_cache,
               fetch_valid, fetch_pc, fetch_inst, fetch_adel
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// PC generator and instruction fetch queue in front of the icache: one request in flight,
// responses buffered with their PC in a small FIFO, redirects flush and drop in-flight data.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.master  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } entry_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic            stall_q, stall_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];

    logic            push;
    entry_t          push_entry;
    logic            pop;
    logic            req;
    logic            credit;
    logic [CW-1:0]   used;
    logic            head_valid;
    entry_t          head;

    assign head_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        stall_d    = stall_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        push_entry = '0;
        pop        = 1'b0;
        req        = 1'b0;

        // A slot is reserved for the outstanding request, so it counts against capacity.
        used   = count_q + CW'(state_q != S_IDLE);
        credit = (used < CW'(DEPTH));

        if (bus.redirect) begin
            pc_d     = bus.redirect_pc;
            stall_d  = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            if (state_q == S_IDLE || bus.inst_data_ok)
                state_d = S_IDLE;
            else
                state_d = S_DISCARD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!stall_q && credit && pc_q[1:0] != 2'b00) begin
                        push            = 1'b1;
                        push_entry.pc   = pc_q;
                        push_entry.adel = 1'b1;
                        stall_d         = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.inst_data_ok) begin
                        push            = 1'b1;
                        push_entry.pc   = req_addr_q;
                        push_entry.inst = bus.inst_rdata;
                        state_d         = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (bus.inst_data_ok)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // Back-to-back: the response cycle may already launch the next request.
            req = !rst && !stall_q && credit && (pc_q[1:0] == 2'b00) &&
                  (state_q == S_IDLE || (state_q == S_WAIT && bus.inst_data_ok));
            if (req && bus.inst_addr_ok) begin
                pc_d       = pc_q + 32'd4;
                req_addr_d = pc_q;
                state_d    = S_WAIT;
            end

            pop = head_valid && bus.fetch_ready;
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            stall_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            stall_q    <= stall_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wr_ptr_q] <= push_entry;
    end

    assign bus.inst_req    = req;
    assign bus.inst_wr     = 1'b0;
    assign bus.inst_size   = 2'b10;
    assign bus.inst_addr   = pc_q;
    assign bus.inst_wdata  = 32'd0;
    assign bus.inst_cache  = (pc_q[31:29] != 3'b101);

    assign bus.fetch_valid = head_valid;
    assign bus.fetch_pc    = head_valid ? head.pc   : 32'd0;
    assign bus.fetch_inst  = head_valid ? head.inst : 32'd0;
    assign bus.fetch_adel  = head_valid ? head.adel : 1'b0;
endmodule
